// File: rtl/vend_coin_payer.sv
// Customer-side coin initiator: plays a (10s, 5s) payment plan into a price-20 Mealy vending FSM
// and counts its dispense/chg5 responses. Optional abort input enabled by defining PAYER_ABORT_EN.
module vend_coin_payer #(
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 1,
  parameter int ORDER   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] plan_10,
  input  logic [CNT_W-1:0] plan_5,
  input  logic             dispense,
  input  logic             chg5,
  output logic [1:0]       coin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vend_cnt,
  output logic [CNT_W-1:0] chg_cnt
`ifdef PAYER_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_FIVE = 2'b01;
  localparam logic [1:0] C_TEN  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_COIN, S_GAP, S_DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       coin_nx;
  logic [CNT_W-1:0] rem10, rem10_nx, rem5, rem5_nx;
  logic [CNT_W-1:0] vend_nx, chg_nx;
  logic [GW-1:0]    gap, gap_nx;
  logic             abort_req;

`ifdef PAYER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Only called while at least one coin remains, so the fallback denomination is always available.
  function automatic logic [1:0] choose(input logic [CNT_W-1:0] n10, input logic [CNT_W-1:0] n5);
    if (ORDER == 0) return (n10 != '0) ? C_TEN : C_FIVE;
    else            return (n5 != '0) ? C_FIVE : C_TEN;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      coin     <= C_NONE;
      rem10    <= '0;
      rem5     <= '0;
      gap      <= '0;
      vend_cnt <= '0;
      chg_cnt  <= '0;
    end else begin
      state    <= state_nx;
      coin     <= coin_nx;
      rem10    <= rem10_nx;
      rem5     <= rem5_nx;
      gap      <= gap_nx;
      vend_cnt <= vend_nx;
      chg_cnt  <= chg_nx;
    end
  end

  // The coin register is loaded with the coin belonging to the next state, giving one coin per COIN cycle.
  always_comb begin
    state_nx = state;
    coin_nx  = C_NONE;
    rem10_nx = rem10;
    rem5_nx  = rem5;
    gap_nx   = gap;
    vend_nx  = vend_cnt;
    chg_nx   = chg_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          vend_nx = '0;
          chg_nx  = '0;
          if ((plan_10 != '0) || (plan_5 != '0)) begin
            rem10_nx = plan_10;
            rem5_nx  = plan_5;
            coin_nx  = choose(plan_10, plan_5);
            state_nx = S_COIN;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_COIN: begin
        if (dispense && (vend_cnt != CNT_MAX)) vend_nx = vend_cnt + CNT_ONE;
        if (chg5 && (chg_cnt != CNT_MAX))      chg_nx  = chg_cnt + CNT_ONE;
        if ((coin == C_TEN) && (rem10 != '0))      rem10_nx = rem10 - CNT_ONE;
        else if ((coin == C_FIVE) && (rem5 != '0)) rem5_nx  = rem5 - CNT_ONE;
        gap_nx   = GAP_LAST;
        state_nx = abort_req ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if (abort_req) begin
          state_nx = S_DONE;
        end else if (gap != '0) begin
          gap_nx = gap - GAP_ONE;
        end else if ((rem10 != '0) || (rem5 != '0)) begin
          coin_nx  = choose(rem10, rem5);
          state_nx = S_COIN;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_COIN) || (state == S_GAP);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_vend_coin_payer.sv
// Scoreboard bench: two payers (ORDER=0 and ORDER=1) share stimulus, each feeding its own price-20 vending model.
module tb_vend_coin_payer;
  localparam int CNT_W = 4;
  localparam int GAP   = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             vendClr = 1'b0;
  logic [CNT_W-1:0] plan_10 = '0;
  logic [CNT_W-1:0] plan_5 = '0;
`ifdef PAYER_ABORT_EN
  logic             abort = 1'b0;
`endif

  logic [1:0]       coin [2];
  logic             busy [2];
  logic             done [2];
  logic             dispense [2];
  logic             chg5 [2];
  logic [CNT_W-1:0] vend_cnt [2];
  logic [CNT_W-1:0] chg_cnt [2];

  int cyc = 0;
  int startCyc = 0;
  int checks = 0;
  int errors = 0;
  int doneCnt [2] = '{0, 0};
  logic [1:0] expCoin [2][$];
  int expVend [2][$];
  int expChg [2][$];
  int expLat [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int coinVal(input logic [1:0] c);
    return (c == 2'b10) ? 10 : ((c == 2'b01) ? 5 : 0);
  endfunction

  task automatic checkOutput(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s (payer %0d): got %0d, expected %0d at cycle %0d", name, inst, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_env
    int credit = 0;

    vend_coin_payer #(.CNT_W(CNT_W), .GAP_CYC(GAP), .ORDER(g)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .plan_10(plan_10), .plan_5(plan_5),
      .dispense(dispense[g]), .chg5(chg5[g]), .coin(coin[g]), .busy(busy[g]), .done(done[g]),
      .vend_cnt(vend_cnt[g]), .chg_cnt(chg_cnt[g])
`ifdef PAYER_ABORT_EN
      , .abort(abort)
`endif
    );

    // Price-20 Mealy vending machine: responds combinationally to the coin presented this cycle.
    assign dispense[g] = (coinVal(coin[g]) != 0) && (credit + coinVal(coin[g]) >= 20);
    assign chg5[g]     = (coinVal(coin[g]) != 0) && (credit + coinVal(coin[g]) == 25);

    always @(posedge clk) begin
      if (vendClr || !rst_n)          credit <= 0;
      else if (coinVal(coin[g]) != 0) credit <= dispense[g] ? 0 : credit + coinVal(coin[g]);
    end

    always @(negedge clk) begin
      if (coin[g] == 2'b11) checkOutput("coin_illegal", g, coin[g], 0);
      if (coin[g] == 2'b01 || coin[g] == 2'b10) begin
        checkOutput("busy_during_coin", g, busy[g], 1);
        if (expCoin[g].size() == 0) checkOutput("coin_unexpected", g, coin[g], 0);
        else checkOutput("coin_seq", g, coin[g], expCoin[g].pop_front());
      end
      if (done[g] === 1'b1) begin
        doneCnt[g]++;
        checkOutput("busy_at_done", g, busy[g], 0);
        if (expVend[g].size() == 0) begin
          checkOutput("done_unexpected", g, done[g], 0);
        end else begin
          checkOutput("vend_cnt", g, vend_cnt[g], expVend[g].pop_front());
          checkOutput("chg_cnt", g, chg_cnt[g], expChg[g].pop_front());
          checkOutput("done_latency", g, cyc - startCyc, expLat[g].pop_front());
        end
      end
    end
  end

  // Reference: lay out the coin list by order, then replay price-20 credit arithmetic over the coins sent.
  task automatic pushExpect(input int p10, input int p5, input int maxCoins, input bit withDone, input int lat);
    for (int g = 0; g < 2; g++) begin
      int cr = 0;
      int nv = 0;
      int nc = 0;
      for (int k = 0; k < p10 + p5 && k < maxCoins; k++) begin
        bit ten = (g == 0) ? (k < p10) : (k >= p5);
        expCoin[g].push_back(ten ? 2'b10 : 2'b01);
        cr += ten ? 10 : 5;
        if (cr >= 20) begin
          if (nv < 15) nv++;
          if (cr == 25 && nc < 15) nc++;
          cr = 0;
        end
      end
      if (withDone) begin
        expVend[g].push_back(nv);
        expChg[g].push_back(nc);
        expLat[g].push_back(lat);
      end
    end
  endtask

  task automatic applyStimulus(input int p10, input int p5, input int abortAfter, input int resetCoin,
                               input int restartAt);
    int n = p10 + p5;
    int lat = (n == 0) ? 1 : n * (1 + GAP) + 1;
    int maxCoins = n;
    int abortM = (abortAfter - 1) * (1 + GAP) + 2;
    int resetM = (resetCoin - 1) * (1 + GAP) + 1;
    int d0 = doneCnt[0];
    int d1 = doneCnt[1];
    bit finished = 1'b0;
    if (abortAfter > 0) begin
      lat = abortM + 1;
      maxCoins = abortAfter;
    end
    if (resetCoin > 0) maxCoins = resetCoin;
    @(negedge clk);
    pushExpect(p10, p5, maxCoins, resetCoin == 0, lat);
    startCyc = cyc;
    start = 1'b1;
    vendClr = 1'b1;
    plan_10 = CNT_W'(p10);
    plan_5 = CNT_W'(p5);
    for (int m = 1; m <= lat + 6 && !finished; m++) begin
      @(negedge clk);
      if (m == 1) begin
        start = 1'b0;
        vendClr = 1'b0;
        plan_10 = CNT_W'($urandom);
        plan_5 = CNT_W'($urandom);
      end
      if (m == restartAt) begin
        start = 1'b1;
        plan_10 = CNT_W'(3);
      end else if (m == restartAt + 1) begin
        start = 1'b0;
      end
`ifdef PAYER_ABORT_EN
      abort = (abortAfter > 0) && (m == abortM);
`endif
      if (resetCoin > 0) begin
        if (m == resetM) rst_n = 1'b0;
        if (m == resetM + 1) begin
          for (int g = 0; g < 2; g++) begin
            checkOutput("coin_after_reset", g, coin[g], 0);
            checkOutput("busy_after_reset", g, busy[g], 0);
          end
          rst_n = 1'b1;
        end
        if (m == resetM + 4) begin
          for (int g = 0; g < 2; g++) begin
            checkOutput("vend_after_reset", g, vend_cnt[g], 0);
            checkOutput("chg_after_reset", g, chg_cnt[g], 0);
          end
          finished = 1'b1;
        end
      end else if (doneCnt[0] > d0 && doneCnt[1] > d1 && start == 1'b0) begin
        finished = 1'b1;
      end
    end
    if (!finished) begin
      errors++;
      checks++;
      $display("[TB] FAIL run_timeout: plan %0d/%0d got no done within %0d cycles", p10, p5, lat + 6);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput("coins_outstanding", g, expCoin[g].size(), 0);
      checkOutput("results_outstanding", g, expVend[g].size(), 0);
      expCoin[g].delete();
      expVend[g].delete();
      expChg[g].delete();
      expLat[g].delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput("reset_coin", g, coin[g], 0);
      checkOutput("reset_busy", g, busy[g], 0);
      checkOutput("reset_done", g, done[g], 0);
      checkOutput("reset_vend", g, vend_cnt[g], 0);
      checkOutput("reset_chg", g, chg_cnt[g], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(2, 0, 0, 0, 0);
    applyStimulus(2, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(4, 0, 0, 2, 0);
    applyStimulus(2, 0, 0, 0, 2);
    applyStimulus(2, 0, 0, 0, 5);
    applyStimulus(15, 15, 0, 0, 0);
`ifdef PAYER_ABORT_EN
    applyStimulus(4, 0, 1, 0, 0);
    applyStimulus(3, 3, 4, 0, 0);
`endif

    for (int r = 0; r < 40; r++) begin
      int p10 = $urandom_range(0, 6);
      int p5 = $urandom_range(0, 6);
      int lat = (p10 + p5) * (1 + GAP) + 1;
      int rs = 0;
      if (p10 + p5 > 0 && $urandom_range(0, 1) == 1) rs = $urandom_range(2, lat);
      applyStimulus(p10, p5, 0, 0, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
